// File: rtl/sbit_align_pkg.sv
// Shared constants and state encoding for the S-bit aligner supervisor.
package sbit_align_pkg;

    localparam int VFAT_IDX_BITS        = 5;
    localparam int DEF_NVFAT            = 24;
    localparam int DEF_RESET_CYCLES     = 8;
    localparam int DEF_SETTLE_CYCLES    = 64;
    localparam int DEF_CHECK_CYCLES     = 256;
    localparam int DEF_MAX_RETRIES      = 3;
    localparam int DEF_CNT_BITS         = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETTLE,
        S_CHECK,
        S_NEXT,
        S_MONITOR
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sbit_align_supervisor_sat_counter.sv
// Saturating error counter; clear has priority over increment.
module sat_counter #(
    parameter int CNT_BITS = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                inc,
    input  logic                clr,
    output logic [CNT_BITS-1:0] count
);

    always_ff @(posedge clock) begin
        if (!reset_n || clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_BITS'(1);
    end

endmodule

// File: rtl/sbit_align_supervisor.sv
// Sequences reset/lock/qualification of each S-bit aligner, auto-masks failures,
// and monitors for lost lock with optional single-VFAT re-alignment.
module sbit_align_supervisor
    import sbit_align_pkg::*;
#(
    parameter int NVFAT         = DEF_NVFAT,
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CHECK_CYCLES  = DEF_CHECK_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_BITS      = DEF_CNT_BITS
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     auto_realign,
    input  logic                     cnt_reset,
    input  logic [NVFAT-1:0]         cfg_mask,
    input  logic [NVFAT-1:0]         aligner_ready,
    input  logic [NVFAT-1:0]         alignment_error,
    output logic [NVFAT-1:0]         aligner_reset,
    output logic [NVFAT-1:0]         aligner_mask,
    output logic [NVFAT-1:0]         auto_mask,
    output logic [NVFAT-1:0]         aligned,
    output logic                     busy,
    output logic                     done,
    output logic [VFAT_IDX_BITS-1:0] cur_vfat,
    input  logic [VFAT_IDX_BITS-1:0] cnt_sel,
    output logic [CNT_BITS-1:0]      cnt_out
);

    localparam int TW = $clog2(max3(RESET_CYCLES, SETTLE_CYCLES, CHECK_CYCLES) + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [TW-1:0] T_RST_END = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] T_SET_END = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] T_CHK_END = TW'(CHECK_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST    = RW'(MAX_RETRIES - 1);

    state_t                   state, state_n;
    logic [VFAT_IDX_BITS-1:0] idx, idx_n, pick_idx;
    logic [RW-1:0]            retries, retries_n;
    logic [TW-1:0]            timer, timer_n;
    logic                     sweep, sweep_n, done_n, fail, pick_any, in_svc;
    logic [NVFAT-1:0]         aligned_n, auto_mask_n, cfg_mask_q, cand;
    logic [NVFAT-1:0]         reset_v, mask_v;
    logic [NVFAT-1:0][CNT_BITS-1:0] cnt;

    // Lowest-index aligned VFAT reporting an error gets re-aligned first.
    assign cand = aligned & alignment_error;
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        for (int i = NVFAT - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick_any = 1'b1;
                pick_idx = VFAT_IDX_BITS'(i);
            end
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        retries_n   = retries;
        timer_n     = timer;
        sweep_n     = sweep;
        aligned_n   = aligned;
        auto_mask_n = auto_mask;
        done_n      = 1'b0;
        fail        = 1'b0;
        if (start && (state == S_IDLE || state == S_MONITOR)) begin
            aligned_n   = '0;
            auto_mask_n = '0;
            retries_n   = '0;
            timer_n     = '0;
            sweep_n     = 1'b1;
            idx_n       = '0;
            state_n     = cfg_mask[0] ? S_NEXT : S_RST;
        end else begin
            case (state)
                S_RST: begin
                    timer_n = timer + TW'(1);
                    if (timer == T_RST_END) begin
                        timer_n = '0;
                        state_n = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    timer_n = timer + TW'(1);
                    if (aligner_ready[idx]) begin
                        timer_n = '0;
                        state_n = S_CHECK;
                    end else if (timer == T_SET_END) begin
                        fail = 1'b1;
                    end
                end
                S_CHECK: begin
                    timer_n = timer + TW'(1);
                    if (alignment_error[idx] || !aligner_ready[idx]) begin
                        fail = 1'b1;
                    end else if (timer == T_CHK_END) begin
                        aligned_n[idx] = 1'b1;
                        state_n        = S_NEXT;
                    end
                end
                S_NEXT: begin
                    retries_n = '0;
                    timer_n   = '0;
                    if (sweep && int'(idx) < NVFAT - 1) begin
                        idx_n   = idx + VFAT_IDX_BITS'(1);
                        state_n = cfg_mask[idx_n] ? S_NEXT : S_RST;
                    end else begin
                        sweep_n = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_MONITOR;
                    end
                end
                S_MONITOR: begin
                    if (auto_realign && pick_any) begin
                        idx_n               = pick_idx;
                        aligned_n[pick_idx] = 1'b0;
                        retries_n           = '0;
                        timer_n             = '0;
                        state_n             = S_RST;
                    end
                end
                default: ;
            endcase
        end
        if (fail) begin
            timer_n = '0;
            if (retries == R_LAST) begin
                auto_mask_n[idx] = 1'b1;
                state_n          = S_NEXT;
            end else begin
                retries_n = retries + RW'(1);
                state_n   = S_RST;
            end
        end
        // Software masking a VFAT invalidates its qualification.
        aligned_n = aligned_n & ~(cfg_mask & ~cfg_mask_q);
    end

    // Aligner-facing vectors are derived from next-state so they register cleanly.
    assign in_svc = (state_n == S_RST) || (state_n == S_SETTLE) || (state_n == S_CHECK);
    always_comb begin
        reset_v = '1;
        mask_v  = '1;
        if (state_n != S_IDLE) begin
            for (int i = 0; i < NVFAT; i++) begin
                reset_v[i] = (sweep_n && i > int'(idx_n)) ||
                             (state_n == S_RST && i == int'(idx_n));
                mask_v[i]  = cfg_mask[i] | auto_mask_n[i] |
                             (in_svc && i == int'(idx_n)) |
                             (sweep_n && i > int'(idx_n));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            retries       <= '0;
            timer         <= '0;
            sweep         <= 1'b0;
            aligned       <= '0;
            auto_mask     <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
            aligner_reset <= '1;
            aligner_mask  <= '1;
            cfg_mask_q    <= '0;
            cnt_out       <= '0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            retries       <= retries_n;
            timer         <= timer_n;
            sweep         <= sweep_n;
            aligned       <= aligned_n;
            auto_mask     <= auto_mask_n;
            done          <= done_n;
            busy          <= (state_n != S_IDLE) && (state_n != S_MONITOR);
            aligner_reset <= reset_v;
            aligner_mask  <= mask_v;
            cfg_mask_q    <= cfg_mask;
            cnt_out       <= (int'(cnt_sel) < NVFAT) ? cnt[cnt_sel] : '0;
        end
    end

    assign cur_vfat = idx;

    for (genvar g = 0; g < NVFAT; g++) begin : g_cnt
        sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .inc     (alignment_error[g] & ~aligner_mask[g]),
            .clr     (cnt_reset),
            .count   (cnt[g])
        );
    end

endmodule

// File: tb/tb_sbit_align_supervisor.sv
// Directed bench for sbit_align_supervisor with a simple aligner model
// (ready two cycles after its reset is released).
module tb_sbit_align_supervisor;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        auto_realign = 1'b0;
    logic        cnt_reset = 1'b0;
    logic [23:0] cfg_mask = '0;
    logic [23:0] aligner_ready;
    logic [23:0] alignment_error = '0;
    logic [23:0] aligner_reset, aligner_mask, auto_mask, aligned;
    logic        busy, done;
    logic [4:0]  cur_vfat;
    logic [4:0]  cnt_sel = '0;
    logic [7:0]  cnt_out;

    logic [23:0] force_notready = '0;
    int          rel [24];
    int          checks = 0;
    int          errors = 0;

    sbit_align_supervisor dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .auto_realign    (auto_realign),
        .cnt_reset       (cnt_reset),
        .cfg_mask        (cfg_mask),
        .aligner_ready   (aligner_ready),
        .alignment_error (alignment_error),
        .aligner_reset   (aligner_reset),
        .aligner_mask    (aligner_mask),
        .auto_mask       (auto_mask),
        .aligned         (aligned),
        .busy            (busy),
        .done            (done),
        .cur_vfat        (cur_vfat),
        .cnt_sel         (cnt_sel),
        .cnt_out         (cnt_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        for (int i = 0; i < 24; i++) begin
            if (aligner_reset[i]) rel[i] <= 0;
            else if (rel[i] < 2)  rel[i] <= rel[i] + 1;
        end
    end

    always_comb begin
        aligner_ready = '0;
        for (int i = 0; i < 24; i++)
            aligner_ready[i] = (rel[i] == 2) && !force_notready[i];
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(3);
        checks++; if (aligner_reset !== 24'hFFFFFF) begin errors++; $display("FAIL rst_aligner_reset got %h exp %h", aligner_reset, 24'hFFFFFF); end
        checks++; if (aligner_mask !== 24'hFFFFFF) begin errors++; $display("FAIL rst_aligner_mask got %h exp %h", aligner_mask, 24'hFFFFFF); end
        checks++; if (auto_mask !== 24'h0) begin errors++; $display("FAIL rst_auto_mask got %h exp 0", auto_mask); end
        checks++; if (aligned !== 24'h0) begin errors++; $display("FAIL rst_aligned got %h exp 0", aligned); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got %b exp 00", {busy, done}); end
        checks++; if (cur_vfat !== 5'd0) begin errors++; $display("FAIL rst_cur_vfat got %0d exp 0", cur_vfat); end
        checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL rst_cnt_out got %0d exp 0", cnt_out); end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_full_sweep;
        int n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || cur_vfat !== 5'd0) begin errors++; $display("FAIL sweep_start busy/cur got %b/%0d exp 1/0", busy, cur_vfat); end
        checks++; if (aligner_reset !== 24'hFFFFFF) begin errors++; $display("FAIL sweep_start_reset got %h exp FFFFFF", aligner_reset); end
        tick(7);
        checks++; if (aligner_reset[0] !== 1'b1) begin errors++; $display("FAIL sweep_rst_hold got %b exp 1", aligner_reset[0]); end
        tick(1);
        checks++; if (aligner_reset[0] !== 1'b0 || aligner_mask[0] !== 1'b1) begin errors++; $display("FAIL sweep_rst_release reset/mask got %b/%b exp 0/1", aligner_reset[0], aligner_mask[0]); end
        n = 8;
        while (!done && n < 8000) begin tick(1); n++; end
        checks++; if (n < 6408 || n > 6456) begin errors++; $display("FAIL sweep_duration got %0d exp 6432+-24", n); end
        checks++; if (aligned !== 24'hFFFFFF) begin errors++; $display("FAIL sweep_aligned got %h exp FFFFFF", aligned); end
        checks++; if (auto_mask !== 24'h0 || busy !== 1'b0) begin errors++; $display("FAIL sweep_automask_busy got %h/%b exp 0/0", auto_mask, busy); end
        tick(1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sweep_done_pulse got %b exp 0", done); end
        checks++; if (aligner_reset !== 24'h0 || aligner_mask !== 24'h0) begin errors++; $display("FAIL monitor_release reset/mask got %h/%h exp 0/0", aligner_reset, aligner_mask); end
    endtask

    task automatic test_realign_priority;
        int n;
        auto_realign = 1'b1;
        alignment_error[3] = 1'b1;
        alignment_error[7] = 1'b1;
        tick(1);
        alignment_error[3] = 1'b0;
        checks++; if (cur_vfat !== 5'd3 || busy !== 1'b1) begin errors++; $display("FAIL realign_pick cur/busy got %0d/%b exp 3/1", cur_vfat, busy); end
        checks++; if (aligned[3] !== 1'b0 || aligned[7] !== 1'b1) begin errors++; $display("FAIL realign_aligned3_7 got %b%b exp 01", aligned[3], aligned[7]); end
        checks++; if (aligner_reset[3] !== 1'b1 || aligner_mask[3] !== 1'b1) begin errors++; $display("FAIL realign_rst3 reset/mask got %b/%b exp 1/1", aligner_reset[3], aligner_mask[3]); end
        n = 0;
        while (!done && n < 400) begin tick(1); n++; end
        checks++; if (done !== 1'b1 || cur_vfat !== 5'd3 || aligned[3] !== 1'b1) begin errors++; $display("FAIL realign3_done done/cur/al got %b/%0d/%b exp 1/3/1", done, cur_vfat, aligned[3]); end
        tick(1);
        checks++; if (cur_vfat !== 5'd7 || busy !== 1'b1 || aligned[7] !== 1'b0) begin errors++; $display("FAIL realign7_pick cur/busy/al got %0d/%b/%b exp 7/1/0", cur_vfat, busy, aligned[7]); end
        alignment_error[7] = 1'b0;
        n = 0;
        while (!done && n < 400) begin tick(1); n++; end
        checks++; if (done !== 1'b1 || aligned !== 24'hFFFFFF) begin errors++; $display("FAIL realign7_done done/aligned got %b/%h exp 1/FFFFFF", done, aligned); end
        cnt_sel = 5'd3;
        tick(1);
        checks++; if (cnt_out !== 8'd1) begin errors++; $display("FAIL cnt3_single got %0d exp 1", cnt_out); end
    endtask

    task automatic test_counter_sat;
        auto_realign = 1'b0;
        alignment_error[9] = 1'b1;
        cnt_sel = 5'd9;
        tick(300);
        checks++; if (cnt_out !== 8'd255) begin errors++; $display("FAIL cnt9_saturate got %0d exp 255", cnt_out); end
        checks++; if (aligned[9] !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL no_realign al/busy got %b/%b exp 1/0", aligned[9], busy); end
        cnt_sel = 5'd30;
        tick(1);
        checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL cnt_out_of_range got %0d exp 0", cnt_out); end
        cnt_sel = 5'd9;
        cnt_reset = 1'b1;
        tick(1);
        cnt_reset = 1'b0;
        alignment_error[9] = 1'b0;
        tick(1);
        checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL cnt_reset_wins got %0d exp 0", cnt_out); end
    endtask

    task automatic test_mask_skip;
        cfg_mask = 24'h000003;
        tick(1);
        checks++; if (aligned !== 24'hFFFFFC) begin errors++; $display("FAIL cfg_mask_clears_aligned got %h exp FFFFFC", aligned); end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        checks++; if (cur_vfat !== 5'd0 || busy !== 1'b1 || aligner_mask[1:0] !== 2'b11) begin errors++; $display("FAIL skip0 cur/busy/mask got %0d/%b/%b exp 0/1/11", cur_vfat, busy, aligner_mask[1:0]); end
        tick(1);
        checks++; if (cur_vfat !== 5'd1 || aligner_mask[1:0] !== 2'b11) begin errors++; $display("FAIL skip1 cur/mask got %0d/%b exp 1/11", cur_vfat, aligner_mask[1:0]); end
        tick(1);
        checks++; if (cur_vfat !== 5'd2 || aligner_reset[2] !== 1'b1 || aligner_reset[1:0] !== 2'b00) begin errors++; $display("FAIL first_rst_idx2 cur/rst got %0d/%b exp 2/100", cur_vfat, aligner_reset[2:0]); end
        checks++; if (aligner_mask !== 24'hFFFFFF) begin errors++; $display("FAIL idx2_mask got %h exp FFFFFF", aligner_mask); end
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        cfg_mask = '0;
        tick(1);
    endtask

    task automatic test_auto_mask;
        int n;
        force_notready = 24'h000020;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 0;
        while (cur_vfat !== 5'd5 && n < 3000) begin tick(1); n++; end
        n = 0;
        while (auto_mask[5] !== 1'b1 && n < 1000) begin tick(1); n++; end
        checks++; if (n != 216) begin errors++; $display("FAIL vfat5_fail_cycles got %0d exp 216", n); end
        checks++; if (aligned[5:0] !== 6'h1F || cur_vfat !== 5'd5) begin errors++; $display("FAIL vfat5_automask al/cur got %h/%0d exp 1F/5", aligned[5:0], cur_vfat); end
        tick(1);
        checks++; if (cur_vfat !== 5'd6 || aligner_mask[5] !== 1'b1) begin errors++; $display("FAIL continue_at6 cur/mask5 got %0d/%b exp 6/1", cur_vfat, aligner_mask[5]); end
        n = 0;
        while (!done && n < 6000) begin tick(1); n++; end
        checks++; if (done !== 1'b1 || aligned !== 24'hFFFFDF || auto_mask !== 24'h000020) begin errors++; $display("FAIL automask_sweep done/al/am got %b/%h/%h exp 1/FFFFDF/000020", done, aligned, auto_mask); end
        cnt_sel = 5'd5;
        tick(1);
        checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL cnt5_zero got %0d exp 0", cnt_out); end
    endtask

    task automatic test_reset_mid_check;
        int n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 0;
        while (cur_vfat !== 5'd12 && n < 6000) begin tick(1); n++; end
        tick(31);
        checks++; if (cur_vfat !== 5'd12 || auto_mask[5] !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL pre_abort cur/am5/busy got %0d/%b/%b exp 12/1/1", cur_vfat, auto_mask[5], busy); end
        reset_n = 1'b0;
        tick(1);
        checks++; if (aligner_reset !== 24'hFFFFFF || aligner_mask !== 24'hFFFFFF) begin errors++; $display("FAIL abort_reset_mask got %h/%h exp FFFFFF/FFFFFF", aligner_reset, aligner_mask); end
        checks++; if (auto_mask !== 24'h0 || aligned !== 24'h0) begin errors++; $display("FAIL abort_am_al got %h/%h exp 0/0", auto_mask, aligned); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cur_vfat !== 5'd0 || cnt_out !== 8'd0) begin errors++; $display("FAIL abort_misc busy/done/cur/cnt got %b/%b/%0d/%0d exp 0/0/0/0", busy, done, cur_vfat, cnt_out); end
        reset_n = 1'b1;
        force_notready = '0;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        checks++; if (cur_vfat !== 5'd0 || busy !== 1'b1 || aligner_reset[0] !== 1'b1) begin errors++; $display("FAIL restart cur/busy/rst0 got %0d/%b/%b exp 0/1/1", cur_vfat, busy, aligner_reset[0]); end
        tick(7);
        checks++; if (aligner_reset[1:0] !== 2'b11) begin errors++; $display("FAIL restart_rst_hold got %b exp 11", aligner_reset[1:0]); end
        tick(1);
        checks++; if (aligner_reset[1:0] !== 2'b10) begin errors++; $display("FAIL restart_rst_release got %b exp 10", aligner_reset[1:0]); end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_realign_priority();
        test_counter_sat();
        test_mask_skip();
        test_auto_mask();
        test_reset_mid_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbit_align_supervisor.md
# sbit_align_supervisor

Supervises the per-VFAT S-bit frame aligners of one OptoHybrid trigger path. It sequences reset and lock of each aligner in turn, verifies lock over a qualification window, and retries or auto-masks aligners that fail. After the sweep it monitors for alignment errors, keeps per-VFAT saturating error counters, and optionally re-aligns a VFAT that loses lock. It sits between the slow-control register file and the bank of frame aligners, in the 40 MHz `clock` domain.

## Interface
- `NVFAT`, 24, number of frame aligners supervised
- `RESET_CYCLES`, 8, cycles `aligner_reset` is held per attempt
- `SETTLE_CYCLES`, 64, cycles allowed for the aligner to reach ready
- `CHECK_CYCLES`, 256, lock qualification window
- `MAX_RETRIES`, 3, failed attempts before auto-mask
- `CNT_BITS`, 8, error counter width
- `clock` in 1: 40 MHz clock
- `reset_n` in 1: reset, synchronous, active-low
- `start` in 1: one-cycle pulse, begins a full sweep
- `auto_realign` in 1: enables re-alignment of VFATs that lose lock
- `cnt_reset` in 1: clears all error counters
- `cfg_mask` in NVFAT: software mask
- `aligner_ready` in NVFAT: aligner ready flags
- `alignment_error` in NVFAT: aligner error flags
- `aligner_reset` out NVFAT: reset to each aligner
- `aligner_mask` out NVFAT: mask to each aligner
- `auto_mask` out NVFAT: VFATs masked after MAX_RETRIES failures
- `aligned` out NVFAT: VFAT passed qualification and has not since failed
- `busy` out 1: state is neither IDLE nor MONITOR
- `done` out 1: one-cycle pulse when a sweep or single re-alignment completes
- `cur_vfat` out 5: index under service
- `cnt_sel` in 5: counter read select
- `cnt_out` out CNT_BITS: registered counter value

## Operation
- States: IDLE, RST, SETTLE, CHECK, NEXT, MONITOR.
- IDLE: every `aligner_reset` bit is 1. Leave IDLE on `start`: set idx=0, clear `aligned`, `auto_mask` and the retry counter.
- The sweep skips any idx with `cfg_mask` set; `aligned[idx]` stays 0.
- RST: drive `aligner_reset[idx]`=1 for RESET_CYCLES, then go to SETTLE.
- SETTLE: wait up to SETTLE_CYCLES for `aligner_ready[idx]`.
  - Ready seen: go to CHECK.
  - Timeout: the attempt fails.
- CHECK: run CHECK_CYCLES.
  - Pass: `aligner_ready[idx]` held and `alignment_error[idx]` never seen. Set `aligned[idx]`=1 and go to NEXT.
  - Otherwise the attempt fails.
- Failed attempt:
  - Increment retries.
  - If retries==MAX_RETRIES: set `auto_mask[idx]`=1 and go to NEXT.
  - Otherwise go to RST.
- NEXT: reset retries.
  - Sweep mode with idx<NVFAT-1: idx++, go to RST.
  - Otherwise: pulse `done` and go to MONITOR.
- During a sweep, VFATs above idx stay in reset. Completed VFATs are released, including auto-masked ones (release only, masked by `aligner_mask`).
- MONITOR, with `auto_realign`=1: if any VFAT with `aligned`=1 has `alignment_error`, the lowest such index is chosen. Its `aligned` bit clears and it runs RST→SETTLE→CHECK in single mode. NEXT then returns to MONITOR.
- `start` in MONITOR begins a new sweep. `start` while `busy` is ignored.
- `aligner_mask` = `cfg_mask` | `auto_mask` | (one-hot idx while in RST/SETTLE/CHECK) | (all VFATs not yet reached in the current sweep).
- When `cfg_mask[i]` rises, `aligned[i]` clears.
- Counters: `cnt[i]` increments each cycle that `alignment_error[i]` & ~`aligner_mask[i]`, and saturates at all-ones. `cnt_reset` clears all counters and wins over a simultaneous increment.
- `cnt_out` is `cnt[cnt_sel]`, registered. An out-of-range `cnt_sel` reads 0.

## Timing
- Reset values while `reset_n`=0:
  - All-ones: `aligner_reset`, `aligner_mask`.
  - Zero: `auto_mask`, `aligned`, `busy`, `done`, `cur_vfat`, `cnt_out`, all counters.
  - State is IDLE.
- `reset_n` low mid-sequence aborts on the next edge with the values above.
- `start` sampled at edge N: state is RST at N+1, and `aligner_reset[0]` is 1 from N+1 to N+RESET_CYCLES.
- Per-VFAT duration:
  - Best case: RESET_CYCLES + 1 + CHECK_CYCLES + 1, with ready in the first SETTLE cycle.
  - Worst case: MAX_RETRIES·(RESET_CYCLES+SETTLE_CYCLES) + 1.
- A masked VFAT costs 1 cycle in NEXT.
- All outputs are registered. `cnt_out` latency is 1 cycle from `cnt_sel`.
- `alignment_error` in CHECK aborts the attempt at the next edge; the window does not run to completion.

## Structure
- Shared localparam header `sbit_align_pkg.vh`:
  - state encodings
  - default cycle constants
  - `VFAT_IDX_BITS`=5
- Sub-module `sat_counter` (CNT_BITS, inc, clr), instantiated NVFAT times.
- The FSM, window timer and lowest-index priority pick stay in the top level.

## Test plan
- All aligners ready 2 cycles after reset release, no errors; `start` → `aligned`=24'hFFFFFF, `done` pulse after 24·(8+1+2+256+1) cycles ±24, `auto_mask`=0.
- VFAT 5 never ready → 3 SETTLE timeouts, then `auto_mask[5]`=1, `aligned[5]`=0; sweep continues at 6; `cnt[5]` stays 0.
- `cfg_mask`=24'h000003 → VFATs 0 and 1 skipped in 1 cycle each, first RST on idx 2, `aligner_mask[1:0]`=2'b11 throughout.
- MONITOR with `auto_realign`=1, errors on VFATs 7 and 3 in the same cycle → 3 serviced first, `aligned[3]` clears, `cur_vfat`=3, `done` on completion; 7 serviced next.
- Error held on VFAT 9 for 300 cycles in MONITOR with `auto_realign`=0 → `cnt[9]`=255 saturated; `cnt_reset` coincident with an error → 0.
- `reset_n` low during CHECK of VFAT 12 → next edge all outputs at reset values; a new `start` restarts at idx 0.
